// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLB management op sequencer and CP0 TLB register file
//
// Purpose:
//   Executes TLBP, TLBR, TLBWI and TLBWR one at a time. Each op takes three
//   cycles: IDLE (accept), EXEC (search/read capture or array write) and
//   DONE (op_done pulse). Owns CP0 Index, Random, EntryHi, EntryLo0 and EntryLo1.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   op_valid_i/op_code_i      op request (00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR)
//   op_ready_o/op_done_o      accept indication, one-cycle completion pulse
//   mtc0_we_i/addr_i/wdata_i  CP0 register write port
//   mfc0_addr_i/mfc0_rdata_o  combinational CP0 register read port
//   s_*                       TLB array search port 1 (request out, result in)
//   we_o, w_*                 TLB array write port
//   r_index_o, r_*            TLB array read port
//
// Configuration:
//   TLB_RANDOM_EN  when defined, the Random register exists, TLBWR writes the
//                  entry selected by Random and mfc0 of register 1 returns it.
//                  When undefined, TLBWR writes at Index and register 1 reads 0.

module tlb_op_ctrl #(
   parameter int TLBNUM = 16,
   localparam int IW = $clog2(TLBNUM)
) (
   input  logic          clk_i,
   input  logic          reset_i,

   input  logic          op_valid_i,
   input  logic [1:0]    op_code_i,
   output logic          op_ready_o,
   output logic          op_done_o,

   input  logic          mtc0_we_i,
   input  logic [4:0]    mtc0_addr_i,
   input  logic [31:0]   mtc0_wdata_i,
   input  logic [4:0]    mfc0_addr_i,
   output logic [31:0]   mfc0_rdata_o,

   output logic [18:0]   s_vpn2_o,
   output logic [7:0]    s_asid_o,
   output logic          s_odd_page_o,
   input  logic          s_found_i,
   input  logic [IW-1:0] s_index_i,

   output logic          we_o,
   output logic [IW-1:0] w_index_o,
   output logic [18:0]   w_vpn2_o,
   output logic [7:0]    w_asid_o,
   output logic          w_g_o,
   output logic [19:0]   w_pfn0_o,
   output logic [2:0]    w_c0_o,
   output logic          w_d0_o,
   output logic          w_v0_o,
   output logic [19:0]   w_pfn1_o,
   output logic [2:0]    w_c1_o,
   output logic          w_d1_o,
   output logic          w_v1_o,

   output logic [IW-1:0] r_index_o,
   input  logic [18:0]   r_vpn2_i,
   input  logic [7:0]    r_asid_i,
   input  logic          r_g_i,
   input  logic [19:0]   r_pfn0_i,
   input  logic [2:0]    r_c0_i,
   input  logic          r_d0_i,
   input  logic          r_v0_i,
   input  logic [19:0]   r_pfn1_i,
   input  logic [2:0]    r_c1_i,
   input  logic          r_d1_i,
   input  logic          r_v1_i
);

   localparam logic [1:0] OP_TLBP  = 2'b00;
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBWR = 2'b11;

   localparam logic [4:0] CP0_INDEX    = 5'd0;
   localparam logic [4:0] CP0_RANDOM   = 5'd1;
   localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;

   // Only the architecturally defined fields are stored; undefined bits read 0.
   logic          idx_p_q, idx_p_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [18:0]   hi_vpn2_q, hi_vpn2_d;
   logic [7:0]    hi_asid_q, hi_asid_d;
   logic [25:0]   lo0_q, lo0_d;     // {PFN, C, D, V, G}
   logic [25:0]   lo1_q, lo1_d;

   logic          exec_tlbp;
   logic          exec_tlbr;
   logic [31:0]   random_rdata;

   // EntryHi bits [12:8] have no storage.
   logic          unused_wdata;
   assign unused_wdata = ^mtc0_wdata_i[12:8];

   // ------------------------------------------------------------------
   // Op sequencer
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid_i) begin
               state_d = S_EXEC;
               op_d    = op_code_i;
            end
         end
         S_EXEC:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         op_q    <= OP_TLBP;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   assign op_ready_o = (state_q == S_IDLE);
   assign op_done_o  = (state_q == S_DONE);
   assign exec_tlbp  = (state_q == S_EXEC) && (op_q == OP_TLBP);
   assign exec_tlbr  = (state_q == S_EXEC) && (op_q == OP_TLBR);

   // Both write ops have op_code[1] set. we_o decodes straight from the state
   // register so an asynchronous reset drops it at once.
   assign we_o = (state_q == S_EXEC) && op_q[1];

   // ------------------------------------------------------------------
   // CP0 register update: mtc0 first, then EXEC captures override it so a
   // capture always wins a same-edge collision.
   // ------------------------------------------------------------------
   always_comb begin
      idx_p_d   = idx_p_q;
      idx_d     = idx_q;
      hi_vpn2_d = hi_vpn2_q;
      hi_asid_d = hi_asid_q;
      lo0_d     = lo0_q;
      lo1_d     = lo1_q;

      if (mtc0_we_i) begin
         case (mtc0_addr_i)
            CP0_INDEX:    idx_d = mtc0_wdata_i[IW-1:0];
            CP0_ENTRYLO0: lo0_d = mtc0_wdata_i[25:0];
            CP0_ENTRYLO1: lo1_d = mtc0_wdata_i[25:0];
            CP0_ENTRYHI: begin
               hi_vpn2_d = mtc0_wdata_i[31:13];
               hi_asid_d = mtc0_wdata_i[7:0];
            end
            default: ;
         endcase
      end

      // On a miss the index field keeps its old value, including against a
      // concurrent mtc0 to Index.
      if (exec_tlbp) begin
         idx_p_d = ~s_found_i;
         idx_d   = s_found_i ? s_index_i : idx_q;
      end

      if (exec_tlbr) begin
         hi_vpn2_d = r_vpn2_i;
         hi_asid_d = r_asid_i;
         lo0_d     = {r_pfn0_i, r_c0_i, r_d0_i, r_v0_i, r_g_i};
         lo1_d     = {r_pfn1_i, r_c1_i, r_d1_i, r_v1_i, r_g_i};
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         idx_p_q   <= 1'b0;
         idx_q     <= '0;
         hi_vpn2_q <= '0;
         hi_asid_q <= '0;
         lo0_q     <= '0;
         lo1_q     <= '0;
      end else begin
         idx_p_q   <= idx_p_d;
         idx_q     <= idx_d;
         hi_vpn2_q <= hi_vpn2_d;
         hi_asid_q <= hi_asid_d;
         lo0_q     <= lo0_d;
         lo1_q     <= lo1_d;
      end
   end

   // ------------------------------------------------------------------
   // Random register and write index selection
   // ------------------------------------------------------------------
`ifdef TLB_RANDOM_EN
   logic [IW-1:0] random_q, random_d;
   logic [IW-1:0] wr_rand_q, wr_rand_d;

   always_comb begin
      random_d  = (random_q == '0) ? IW'(TLBNUM - 1) : random_q - IW'(1);
      // TLBWR targets the Random value seen on the accept edge, not the one
      // present during EXEC.
      wr_rand_d = ((state_q == S_IDLE) && op_valid_i) ? random_q : wr_rand_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         random_q  <= IW'(TLBNUM - 1);
         wr_rand_q <= '0;
      end else begin
         random_q  <= random_d;
         wr_rand_q <= wr_rand_d;
      end
   end

   assign w_index_o    = (op_q == OP_TLBWR) ? wr_rand_q : idx_q;
   assign random_rdata = {{(32-IW){1'b0}}, random_q};
`else
   assign w_index_o    = idx_q;
   assign random_rdata = 32'd0;
`endif

   // ------------------------------------------------------------------
   // Array ports
   // ------------------------------------------------------------------
   assign s_vpn2_o     = hi_vpn2_q;
   assign s_asid_o     = hi_asid_q;
   assign s_odd_page_o = 1'b0;

   assign r_index_o    = idx_q;

   // Write fields come straight from the registers, so an mtc0 landing at
   // the end of EXEC cannot disturb the write in progress.
   assign w_vpn2_o = hi_vpn2_q;
   assign w_asid_o = hi_asid_q;
   assign w_g_o    = lo0_q[0] & lo1_q[0];
   assign w_pfn0_o = lo0_q[25:6];
   assign w_c0_o   = lo0_q[5:3];
   assign w_d0_o   = lo0_q[2];
   assign w_v0_o   = lo0_q[1];
   assign w_pfn1_o = lo1_q[25:6];
   assign w_c1_o   = lo1_q[5:3];
   assign w_d1_o   = lo1_q[2];
   assign w_v1_o   = lo1_q[1];

   // ------------------------------------------------------------------
   // mfc0 read mux
   // ------------------------------------------------------------------
   always_comb begin
      mfc0_rdata_o = 32'd0;
      case (mfc0_addr_i)
         CP0_INDEX:    mfc0_rdata_o = {idx_p_q, {(31-IW){1'b0}}, idx_q};
         CP0_RANDOM:   mfc0_rdata_o = random_rdata;
         CP0_ENTRYLO0: mfc0_rdata_o = {6'd0, lo0_q};
         CP0_ENTRYLO1: mfc0_rdata_o = {6'd0, lo1_q};
         CP0_ENTRYHI:  mfc0_rdata_o = {hi_vpn2_q, 5'd0, hi_asid_q};
         default:      mfc0_rdata_o = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - scoreboard testbench for tlb_op_ctrl

module tb_tlb_op_ctrl;

   localparam int TLBNUM = 16;
   localparam int IW     = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          op_valid = 1'b0;
   logic [1:0]    op_code = 2'b00;
   logic          op_ready_o, op_done_o;
   logic          mtc0_we = 1'b0;
   logic [4:0]    mtc0_addr = 5'd0;
   logic [31:0]   mtc0_wdata = 32'd0;
   logic [4:0]    mfc0_addr = 5'd0;
   logic [31:0]   mfc0_rdata_o;
   logic [18:0]   s_vpn2_o;
   logic [7:0]    s_asid_o;
   logic          s_odd_page_o;
   logic          s_found;
   logic [IW-1:0] s_index;
   logic          we_o;
   logic [IW-1:0] w_index_o;
   logic [18:0]   w_vpn2_o;
   logic [7:0]    w_asid_o;
   logic          w_g_o;
   logic [19:0]   w_pfn0_o, w_pfn1_o;
   logic [2:0]    w_c0_o, w_c1_o;
   logic          w_d0_o, w_v0_o, w_d1_o, w_v1_o;
   logic [IW-1:0] r_index_o;
   logic [18:0]   r_vpn2;
   logic [7:0]    r_asid;
   logic          r_g;
   logic [19:0]   r_pfn0, r_pfn1;
   logic [2:0]    r_c0, r_c1;
   logic          r_d0, r_v0, r_d1, r_v1;

   always #5 clk = ~clk;

   tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk_i(clk), .reset_i(reset),
      .op_valid_i(op_valid), .op_code_i(op_code),
      .op_ready_o(op_ready_o), .op_done_o(op_done_o),
      .mtc0_we_i(mtc0_we), .mtc0_addr_i(mtc0_addr), .mtc0_wdata_i(mtc0_wdata),
      .mfc0_addr_i(mfc0_addr), .mfc0_rdata_o(mfc0_rdata_o),
      .s_vpn2_o(s_vpn2_o), .s_asid_o(s_asid_o), .s_odd_page_o(s_odd_page_o),
      .s_found_i(s_found), .s_index_i(s_index),
      .we_o(we_o), .w_index_o(w_index_o), .w_vpn2_o(w_vpn2_o), .w_asid_o(w_asid_o),
      .w_g_o(w_g_o), .w_pfn0_o(w_pfn0_o), .w_c0_o(w_c0_o), .w_d0_o(w_d0_o),
      .w_v0_o(w_v0_o), .w_pfn1_o(w_pfn1_o), .w_c1_o(w_c1_o), .w_d1_o(w_d1_o),
      .w_v1_o(w_v1_o),
      .r_index_o(r_index_o), .r_vpn2_i(r_vpn2), .r_asid_i(r_asid), .r_g_i(r_g),
      .r_pfn0_i(r_pfn0), .r_c0_i(r_c0), .r_d0_i(r_d0), .r_v0_i(r_v0),
      .r_pfn1_i(r_pfn1), .r_c1_i(r_c1), .r_d1_i(r_d1), .r_v1_i(r_v1)
   );

   // TLB array seen by the DUT: written from the DUT's write port.
   logic [18:0] a_vpn2 [TLBNUM];
   logic [7:0]  a_asid [TLBNUM];
   logic        a_g    [TLBNUM];
   logic [24:0] a_lo0  [TLBNUM];
   logic [24:0] a_lo1  [TLBNUM];
   logic        init_arr = 1'b1;

   always @(posedge clk) begin
      if (init_arr) begin
         for (int i = 0; i < TLBNUM; i++) begin
            a_vpn2[i] <= 19'h7FFF0 + 19'(i);
            a_asid[i] <= 8'(i);
            a_g[i]    <= 1'b0;
            a_lo0[i]  <= '0;
            a_lo1[i]  <= '0;
         end
      end else if (we_o) begin
         a_vpn2[w_index_o] <= w_vpn2_o;
         a_asid[w_index_o] <= w_asid_o;
         a_g[w_index_o]    <= w_g_o;
         a_lo0[w_index_o]  <= {w_pfn0_o, w_c0_o, w_d0_o, w_v0_o};
         a_lo1[w_index_o]  <= {w_pfn1_o, w_c1_o, w_d1_o, w_v1_o};
      end
   end

   always_comb begin
      r_vpn2 = a_vpn2[r_index_o];
      r_asid = a_asid[r_index_o];
      r_g    = a_g[r_index_o];
      {r_pfn0, r_c0, r_d0, r_v0} = a_lo0[r_index_o];
      {r_pfn1, r_c1, r_d1, r_v1} = a_lo1[r_index_o];
   end

   // Lowest matching entry wins.
   always_comb begin
      s_found = 1'b0;
      s_index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (a_vpn2[i] == s_vpn2_o && (a_g[i] || a_asid[i] == s_asid_o)) begin
            s_found = 1'b1;
            s_index = IW'(i);
         end
      end
   end

   int cyc = 0;
   int edges = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or posedge reset) begin
      if (reset) edges <= 0;
      else       edges <= edges + 1;
   end

   // Reference model
   logic        m_p;
   logic [3:0]  m_idx;
   logic [31:0] m_hi, m_lo0, m_lo1;
   logic [18:0] m_vpn2 [TLBNUM];
   logic [7:0]  m_asid [TLBNUM];
   logic        m_g    [TLBNUM];
   logic [24:0] m_lo0a [TLBNUM];
   logic [24:0] m_lo1a [TLBNUM];

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] val;
   } done_t;

   logic [81:0] wq [$];
   done_t       dq [$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rand_val(input int e);
      return ((TLBNUM - 1 - e) % TLBNUM + TLBNUM) % TLBNUM;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a, input int e);
      case (a)
         5'd0:  return {m_p, 27'd0, m_idx};
`ifdef TLB_RANDOM_EN
         5'd1:  return 32'(rand_val(e));
`endif
         5'd2:  return m_lo0;
         5'd3:  return m_lo1;
         5'd10: return m_hi;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_mtc0(input logic [4:0] a, input logic [31:0] d, input bit blk_idx, input bit blk_r);
      case (a)
         5'd0:  if (!blk_idx) m_idx = d[3:0];
         5'd2:  if (!blk_r) m_lo0 = d & 32'h03FF_FFFF;
         5'd3:  if (!blk_r) m_lo1 = d & 32'h03FF_FFFF;
         5'd10: if (!blk_r) m_hi = d & 32'hFFFF_E0FF;
         default: ;
      endcase
   endtask

   task automatic m_reset();
      m_p = 1'b0; m_idx = '0; m_hi = '0; m_lo0 = '0; m_lo1 = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write or a done.
   initial begin
      logic [81:0] wexp;
      done_t       dexp;
      forever begin
         @(negedge clk);
         if (we_o) begin
            if (wq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_we: got we=1 expected none (t=%0t)", $time);
            end else begin
               wexp = wq.pop_front();
               chk("write_fields",
                   {w_index_o, w_vpn2_o, w_asid_o, w_g_o, w_pfn0_o, w_c0_o, w_d0_o, w_v0_o,
                    w_pfn1_o, w_c1_o, w_d1_o, w_v1_o}, wexp);
            end
         end
         if (op_done_o) begin
            if (dq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got op_done=1 expected none (t=%0t)", $time);
            end else begin
               dexp = dq.pop_front();
               chk("done_cycle", 82'(cyc), 82'(dexp.cyc));
               chk("mfc0_at_done", 82'(mfc0_rdata_o), 82'(dexp.val));
            end
         end
      end
   end

   // One complete op: accept cycle (mtc0 m1), EXEC cycle (mtc0 m2), DONE cycle.
   task automatic do_op(input logic [1:0] code,
                        input bit m1v, input logic [4:0] m1a, input logic [31:0] m1d,
                        input bit m2v, input logic [4:0] m2a, input logic [31:0] m2d,
                        input logic [4:0] rda);
      int          e0;
      int          c0;
      logic [3:0]  widx;
      logic        g;
      int          hit;
      chk("op_ready_idle", 82'(op_ready_o), 82'(1));
      op_valid = 1'b1; op_code = code;
      mtc0_we = m1v; mtc0_addr = m1a; mtc0_wdata = m1d;
      mfc0_addr = rda;
      e0 = edges; c0 = cyc;
      if (m1v) m_mtc0(m1a, m1d, 1'b0, 1'b0);
      if (code[1]) begin
`ifdef TLB_RANDOM_EN
         widx = (code == 2'b11) ? 4'(rand_val(e0)) : m_idx;
`else
         widx = m_idx;
`endif
         g = m_lo0[0] & m_lo1[0];
         wq.push_back({widx, m_hi[31:13], m_hi[7:0], g, m_lo0[25:1], m_lo1[25:1]});
         m_vpn2[widx] = m_hi[31:13];
         m_asid[widx] = m_hi[7:0];
         m_g[widx]    = g;
         m_lo0a[widx] = m_lo0[25:1];
         m_lo1a[widx] = m_lo1[25:1];
      end else if (code == 2'b00) begin
         hit = -1;
         for (int i = TLBNUM - 1; i >= 0; i--)
            if (m_vpn2[i] == m_hi[31:13] && (m_g[i] || m_asid[i] == m_hi[7:0])) hit = i;
         if (hit >= 0) begin m_p = 1'b0; m_idx = 4'(hit); end
         else m_p = 1'b1;
      end else begin
         m_hi  = {m_vpn2[m_idx], 5'd0, m_asid[m_idx]};
         m_lo0 = {6'd0, m_lo0a[m_idx], m_g[m_idx]};
         m_lo1 = {6'd0, m_lo1a[m_idx], m_g[m_idx]};
      end
      if (m2v) m_mtc0(m2a, m2d, code == 2'b00, code == 2'b01);
      dq.push_back('{cyc: 32'(c0 + 2), val: m_read(rda, e0 + 2)});
      tick();
      // Requests while busy must be ignored.
      chk("op_ready_busy", 82'(op_ready_o), 82'(0));
      op_valid = 1'($urandom_range(0, 1)); op_code = 2'($urandom_range(0, 3));
      mtc0_we = m2v; mtc0_addr = m2a; mtc0_wdata = m2d;
      tick();
      op_valid = 1'($urandom_range(0, 1)); op_code = 2'($urandom_range(0, 3));
      mtc0_we = 1'b0;
      tick();
      op_valid = 1'b0;
   endtask

   task automatic idle_mtc0(input logic [4:0] a, input logic [31:0] d);
      mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
      m_mtc0(a, d, 1'b0, 1'b0);
      tick();
      mtc0_we = 1'b0;
   endtask

   task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
      mfc0_addr = a;
      #1;
      chk(name, 82'(mfc0_rdata_o), 82'(exp));
   endtask

   function automatic logic [4:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd2;
         3: return 5'd3;
         4: return 5'd10;
         default: return 5'd17;
      endcase
   endfunction

   function automatic logic [31:0] pick_data();
      int k;
      k = $urandom_range(0, TLBNUM - 1);
      if ($urandom_range(0, 1) == 1) return {m_vpn2[k], 5'($urandom), m_asid[k]};
      return $urandom;
   endfunction

   initial begin
      m_reset();
      for (int i = 0; i < TLBNUM; i++) begin
         m_vpn2[i] = 19'h7FFF0 + 19'(i);
         m_asid[i] = 8'(i);
         m_g[i]    = 1'b0;
         m_lo0a[i] = '0;
         m_lo1a[i] = '0;
      end

      // Reset state
      #1;
      chk("rst_op_ready", 82'(op_ready_o), 82'(1));
      chk("rst_op_done", 82'(op_done_o), 82'(0));
      chk("rst_we", 82'(we_o), 82'(0));
      chk_reg("rst_index", 5'd0, 32'd0);
      chk_reg("rst_random", 5'd1, m_read(5'd1, 0));
      chk_reg("rst_entryhi", 5'd10, 32'd0);
      chk_reg("rst_entrylo0", 5'd2, 32'd0);
      tick(); tick();
      init_arr = 1'b0;
      reset = 1'b0;
      tick();

      // TLBWI then TLBR
      idle_mtc0(5'd0, 32'd5);
      idle_mtc0(5'd10, 32'h0000_2012);
      idle_mtc0(5'd2, 32'h0000_0047);
      idle_mtc0(5'd3, 32'h0000_0086);
      do_op(2'b10, 0, 0, 0, 0, 0, 0, 5'd0);
      idle_mtc0(5'd10, 32'd0);
      idle_mtc0(5'd2, 32'd0);
      idle_mtc0(5'd3, 32'd0);
      do_op(2'b01, 0, 0, 0, 0, 0, 0, 5'd10);
      chk_reg("tlbr_entryhi", 5'd10, 32'h0000_2012);
      chk_reg("tlbr_entrylo0", 5'd2, 32'h0000_0046);

      // TLBP hit
      idle_mtc0(5'd0, 32'd0);
      do_op(2'b00, 0, 0, 0, 0, 0, 0, 5'd0);
      chk_reg("tlbp_hit", 5'd0, 32'h0000_0005);

      // TLBP miss
      idle_mtc0(5'd0, 32'd3);
      idle_mtc0(5'd10, 32'h4000_0000);
      do_op(2'b00, 0, 0, 0, 0, 0, 0, 5'd0);
      chk_reg("tlbp_miss", 5'd0, 32'h8000_0003);

      // Collision: mtc0 Index on the TLBP capture edge
      idle_mtc0(5'd0, 32'd2);
      idle_mtc0(5'd10, 32'h6000_0033);
      do_op(2'b10, 0, 0, 0, 0, 0, 0, 5'd0);
      idle_mtc0(5'd0, 32'd7);
      do_op(2'b00, 0, 0, 0, 1, 5'd0, 32'd9, 5'd0);
      chk_reg("collision_index", 5'd0, 32'h0000_0002);

      // TLBWR accepted on the 16th edge after reset release
      reset = 1'b1;
      m_reset();
      tick();
      reset = 1'b0;
      repeat (15) tick();
      do_op(2'b11, 0, 0, 0, 0, 0, 0, 5'd1);

      // Reset during EXEC of a TLBWI
      idle_mtc0(5'd10, 32'h1234_5678);
      op_valid = 1'b1; op_code = 2'b10;
      tick();
      op_valid = 1'b0;
      chk("we_in_exec", 82'(we_o), 82'(1));
      #2 reset = 1'b1;
      m_reset();
      #1;
      chk("rst_exec_we", 82'(we_o), 82'(0));
      chk("rst_exec_ready", 82'(op_ready_o), 82'(1));
      chk("rst_exec_done", 82'(op_done_o), 82'(0));
      chk_reg("rst_exec_hi", 5'd10, 32'd0);
      chk_reg("rst_exec_idx", 5'd0, 32'd0);
      chk_reg("rst_exec_rnd", 5'd1, m_read(5'd1, 0));
      @(posedge clk);
      #1 reset = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [4:0]  a1, a2;
         logic [31:0] d1, d2;
         bit          v1, v2;
         int          gap;
         gap = $urandom_range(0, 2);
         for (int j = 0; j < gap; j++) begin
            if ($urandom_range(0, 1) == 1) idle_mtc0(pick_addr(), pick_data());
            else tick();
         end
         v1 = 1'($urandom_range(0, 1)); a1 = pick_addr(); d1 = pick_data();
         v2 = 1'($urandom_range(0, 1)); a2 = pick_addr(); d2 = pick_data();
         do_op(2'($urandom_range(0, 3)), v1, a1, d1, v2, a2, d2, pick_addr());
      end

      repeat (4) tick();
      chk("write_queue_drained", 82'(wq.size()), 82'(0));
      chk("done_queue_drained", 82'(dq.size()), 82'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
